// File: rtl/arm_alu_pipe.sv
// ARM data-processing ALU with NZCV flag register and condition evaluation.
// Latency: 1 cycle from accept to registered result.
// Backpressure: single output slot; in_ready = ~out_valid | out_ready.
module arm_alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_sel,
  input  logic [3:0]       cond,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             shift_carry,
  input  logic             flags_wr,
  input  logic [3:0]       flags_wr_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_we,
  output logic             executed,
  output logic [3:0]       flags
);

  localparam logic [3:0] OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100, OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000, OP_TEQ = 4'b1001, OP_CMP = 4'b1010, OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_BIC = 4'b1110, OP_MVN = 4'b1111;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_we_q, result_we_d;
  logic             executed_q, executed_d;
  logic [3:0]       flags_q, flags_d;

  logic             accept;
  logic             flag_n, flag_z, flag_c, flag_v;
  logic             cond_pass;
  logic [WIDTH-1:0] a, b, logic_res, alu_res;
  logic             cin, arith, test_op;
  logic [WIDTH:0]   sum;
  logic [3:0]       new_flags;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
  assign in_ready  = ~out_valid_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign test_op   = (op_sel[3:2] == 2'b10);

  // Condition field evaluated against the flags currently in the register.
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Operand selection for the shared adder and the logical result per opcode.
  always_comb begin
    a         = op1;
    b         = op2;
    cin       = 1'b0;
    arith     = 1'b1;
    logic_res = '0;
    case (op_sel)
      OP_AND, OP_TST: begin arith = 1'b0; logic_res = op1 & op2;  end
      OP_EOR, OP_TEQ: begin arith = 1'b0; logic_res = op1 ^ op2;  end
      OP_ORR:         begin arith = 1'b0; logic_res = op1 | op2;  end
      OP_MOV:         begin arith = 1'b0; logic_res = op2;        end
      OP_BIC:         begin arith = 1'b0; logic_res = op1 & ~op2; end
      OP_MVN:         begin arith = 1'b0; logic_res = ~op2;       end
      OP_SUB, OP_CMP: begin b = ~op2; cin = 1'b1;   end
      OP_SBC:         begin b = ~op2; cin = flag_c; end
      OP_RSB:         begin a = op2; b = ~op1; cin = 1'b1;   end
      OP_RSC:         begin a = op2; b = ~op1; cin = flag_c; end
      OP_ADC:         begin cin = flag_c; end
      default:        begin cin = 1'b0; end   // ADD, CMN
    endcase
    sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    alu_res = arith ? sum[WIDTH-1:0] : logic_res;
    new_flags[3] = alu_res[WIDTH-1];
    new_flags[2] = (alu_res == '0);
    new_flags[1] = arith ? sum[WIDTH] : shift_carry;
    new_flags[0] = arith ? ((a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1])) : flag_v;
  end

  // Output slot and flag next-state; a direct flag write overrides an ALU update.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    result_we_d = result_we_q;
    executed_d  = executed_q;
    flags_d     = flags_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      executed_d  = cond_pass;
      result_we_d = cond_pass & ~test_op;
      if (cond_pass & (set_flags | test_op)) flags_d = new_flags;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (flags_wr) flags_d = flags_wr_data;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_we_q <= 1'b0;
      executed_q  <= 1'b0;
      flags_q     <= 4'b0000;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_we_q <= result_we_d;
      executed_q  <= executed_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_we = result_we_q;
  assign executed  = executed_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_arm_alu_pipe.sv
// Directed bench for arm_alu_pipe at WIDTH=32.
// Inputs driven 1 time unit after each rising edge; outputs sampled there too.
// Consumer readiness is driven explicitly to exercise stall and release.
module tb_arm_alu_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [3:0]   op_sel, cond;
  logic         set_flags;
  logic [W-1:0] op1, op2;
  logic         shift_carry, flags_wr;
  logic [3:0]   flags_wr_data;
  logic         out_valid, out_ready;
  logic [W-1:0] result;
  logic         result_we, executed;
  logic [3:0]   flags;

  int n_tests = 0;
  int n_fail  = 0;

  arm_alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .cond(cond), .set_flags(set_flags), .op1(op1), .op2(op2),
    .shift_carry(shift_carry), .flags_wr(flags_wr), .flags_wr_data(flags_wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_we(result_we), .executed(executed), .flags(flags)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] AL = 4'b1110, NE = 4'b0001, GE = 4'b1010, LT = 4'b1011, NV = 4'b1111;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [3:0] op, input logic [3:0] c, input logic s,
                     input logic [W-1:0] a, input logic [W-1:0] b, input logic sc);
    in_valid    = 1'b1;
    op_sel      = op;
    cond        = c;
    set_flags   = s;
    op1         = a;
    op2         = b;
    shift_carry = sc;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op_sel = '0; cond = AL; set_flags = 1'b0;
    op1 = '0; op2 = '0; shift_carry = 1'b0; flags_wr = 1'b0; flags_wr_data = '0;
    out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_result_we", result_we, 0);
    chk("rst_executed", executed, 0);
    chk("rst_flags", flags, 4'b0000);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    // 1: ADDS overflow to zero, then ADC consumes the carry
    drv(4'b0100, AL, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0);
    tick();
    chk("adds_result", result, 0);
    chk("adds_we", result_we, 1);
    chk("adds_valid", out_valid, 1);
    chk("adds_flags", flags, 4'b0110);
    drv(4'b0101, AL, 1'b0, 32'd5, 32'd5, 1'b0);
    tick();
    chk("adc_result", result, 32'h0B);
    chk("adc_flags", flags, 4'b0110);

    // 2: SUBS signed overflow, RSBS borrow, then LT/GE/NV conditions
    drv(4'b0010, AL, 1'b1, 32'h8000_0000, 32'h1, 1'b0);
    tick();
    chk("subs_result", result, 32'h7FFF_FFFF);
    chk("subs_flags", flags, 4'b0011);
    drv(4'b0011, AL, 1'b1, 32'd5, 32'd3, 1'b0);
    tick();
    chk("rsbs_result", result, 32'hFFFF_FFFE);
    chk("rsbs_flags", flags, 4'b1000);
    drv(4'b0100, LT, 1'b0, 32'd1, 32'd1, 1'b0);
    tick();
    chk("lt_exec", executed, 1);
    chk("lt_result", result, 32'd2);
    drv(4'b0100, GE, 1'b0, 32'd1, 32'd1, 1'b0);
    tick();
    chk("ge_exec", executed, 0);
    chk("ge_we", result_we, 0);
    drv(4'b0100, NV, 1'b1, 32'd0, 32'd0, 1'b0);
    tick();
    chk("nv_exec", executed, 0);
    chk("nv_flags", flags, 4'b1000);

    // 3: CMP equal, then conditional NE back-to-back
    drv(4'b1010, AL, 1'b0, 32'd7, 32'd7, 1'b0);
    tick();
    chk("cmp_flags", flags, 4'b0110);
    chk("cmp_we", result_we, 0);
    chk("cmp_exec", executed, 1);
    drv(4'b0100, NE, 1'b1, 32'd1, 32'd2, 1'b0);
    tick();
    chk("ne_exec", executed, 0);
    chk("ne_we", result_we, 0);
    chk("ne_valid", out_valid, 1);
    chk("ne_flags", flags, 4'b0110);

    // logical ops, no S
    drv(4'b1100, AL, 1'b0, 32'hF0, 32'h0F, 1'b0); tick();
    chk("orr_result", result, 32'hFF);
    drv(4'b1110, AL, 1'b0, 32'hFF, 32'h0F, 1'b0); tick();
    chk("bic_result", result, 32'hF0);
    drv(4'b0001, AL, 1'b0, 32'hFF, 32'h0F, 1'b0); tick();
    chk("eor_result", result, 32'hF0);
    drv(4'b1111, AL, 1'b0, 32'h0, 32'h0, 1'b0); tick();
    chk("mvn_result", result, 32'hFFFF_FFFF);

    // 4: MOVS keeps V, takes shifter carry; TSTS same flags without write-back
    in_valid = 1'b0; flags_wr = 1'b1; flags_wr_data = 4'b0001;
    tick();
    flags_wr = 1'b0;
    chk("msr_flags", flags, 4'b0001);
    drv(4'b1101, AL, 1'b1, 32'h0, 32'h0, 1'b1);
    tick();
    chk("movs_flags", flags, 4'b0111);
    chk("movs_we", result_we, 1);
    in_valid = 1'b0; flags_wr = 1'b1; flags_wr_data = 4'b0001;
    tick();
    flags_wr = 1'b0;
    drv(4'b1000, AL, 1'b1, 32'h0F, 32'hF0, 1'b1);
    tick();
    chk("tsts_flags", flags, 4'b0111);
    chk("tsts_we", result_we, 0);
    chk("tsts_exec", executed, 1);

    // 5: stall for 3 cycles, release, and MSR overriding CMPS
    drv(4'b0100, AL, 1'b0, 32'd100, 32'd1, 1'b0);
    tick();
    chk("pre_stall_result", result, 32'd101);
    out_ready = 1'b0;
    drv(4'b0100, AL, 1'b0, 32'd10, 32'd20, 1'b0);
    #1;
    chk("stall_in_ready0", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_result", result, 32'd101);
      chk("stall_we", result_we, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    tick();
    chk("release_result", result, 32'd30);
    chk("release_valid", out_valid, 1);
    drv(4'b1010, AL, 1'b1, 32'd3, 32'd3, 1'b0);
    flags_wr = 1'b1; flags_wr_data = 4'b1010;
    tick();
    flags_wr = 1'b0;
    chk("msr_wins_flags", flags, 4'b1010);
    chk("msr_cmp_result", result, 0);

    // 6: asynchronous reset during a stall
    drv(4'b0100, AL, 1'b0, 32'd1, 32'd1, 1'b0);
    flags_wr = 1'b1; flags_wr_data = 4'b1111;
    tick();
    flags_wr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("prerst_flags", flags, 4'b1111);
    tick();
    chk("prerst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_flags", flags, 4'b0000);
    chk("midrst_result", result, 0);
    chk("midrst_in_ready", in_ready, 1);
    rst = 1'b0;
    out_ready = 1'b1;
    drv(4'b0101, AL, 1'b0, 32'd1, 32'd1, 1'b0);
    tick();
    chk("postrst_adc", result, 32'd2);
    chk("postrst_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/arm_alu_pipe.md
# arm_alu_pipe

Parametrised, registered successor to the combinational ARM data-processing ALU. It executes all 16 data-processing opcodes at configurable width. It owns the architectural NZCV flag register, so ADC/SBC/RSC read a real carry. It also evaluates the ARM condition field, and it sits between the operand/shifter stage and register write-back through valid/ready handshakes on both sides.

## Interface
- `WIDTH`, 32: operand/result width; minimum 4.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  an operation is presented.
- `in_ready`  out  1  the block accepts the operation this cycle.
- `op_sel`  in  4  opcode: AND 0000, EOR 0001, SUB 0010, RSB 0011, ADD 0100, ADC 0101, SBC 0110, RSC 0111, TST 1000, TEQ 1001, CMP 1010, CMN 1011, ORR 1100, MOV 1101, BIC 1110, MVN 1111.
- `cond`  in  4  ARM condition field.
- `set_flags`  in  1  S bit.
- `op1`, `op2`  in  WIDTH  operands; `op2` is already shifted.
- `shift_carry`  in  1  shifter carry-out, used as C by logical ops.
- `flags_wr`  in  1  direct flag write (MSR).
- `flags_wr_data`  in  4  flag value for the direct write, ordered {N,Z,C,V}.
- `out_valid`  out  1  the result register holds an operation.
- `out_ready`  in  1  the consumer takes the result.
- `result`  out  WIDTH  ALU result.
- `result_we`  out  1  the destination must be written: the op executed and is not TST/TEQ/CMP/CMN.
- `executed`  out  1  the condition passed.
- `flags`  out  4  current NZCV register, ordered {N,Z,C,V}.

## Operation
- Accept: `in_valid & in_ready`. `in_ready = ~out_valid | out_ready`, so there is one output slot and full throughput under a continuously ready consumer.
- Condition evaluation uses the `flags` value at the accept cycle:
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V.
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V).
  - AL 1110 always passes; 1111 never passes.
- Arithmetic is a WIDTH+1-bit sum `a + b + cin`, with C = bit WIDTH. Operand and carry-in per opcode:
  - ADD/CMN: a=op1, b=op2, cin=0.
  - ADC: a=op1, b=op2, cin=C.
  - SUB/CMP: a=op1, b=~op2, cin=1.
  - SBC: a=op1, b=~op2, cin=C.
  - RSB: a=op2, b=~op1, cin=1.
  - RSC: a=op2, b=~op1, cin=C.
- Arithmetic V = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]). Carry therefore means "no borrow" for subtraction.
- Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN) set C=`shift_carry` and leave V unchanged.
- All ops: N = result[MSB]; Z = (result==0).
- Flag register update on accept, when executed and (`set_flags` or op is TST/TEQ/CMP/CMN). Test ops always update flags regardless of S.
- When the condition fails:
  - `executed`=0 and `result_we`=0.
  - `result` holds the computed value but is don't-care for checking.
  - Flags are unchanged.
  - The op still occupies the output slot and completes the handshake.
- `flags_wr` loads `flags_wr_data` at the edge it is sampled high, independent of handshakes. If it coincides with a flag-updating accept, `flags_wr` wins.
- Test ops produce `result` (the AND/XOR/diff/sum) with `result_we`=0.

## Timing
- Latency: 1 cycle. An op accepted at edge k drives `result`, `result_we`, `executed` and `out_valid` from edge k onward, until consumed.
- Flags written at edge k are visible on `flags` after edge k. An op accepted at edge k+1 uses them, so back-to-back CMP then conditional op, or ADDS then ADC, needs no stall.
- While `out_valid & ~out_ready`:
  - `in_ready`=0.
  - All outputs hold stable.
  - Flags hold, except for `flags_wr`.
- Simultaneous consume and accept: the new result replaces the old one in the same edge, and `out_valid` stays 1.
- Reset (asynchronous, any time, including mid-stall):
  - `out_valid`=0, `result`=0, `result_we`=0, `executed`=0, `flags`=0000.
  - `in_ready`=1 combinationally after reset.
  - An in-flight result is discarded.
- Width rule: all internal arithmetic is WIDTH+1 bits. No sign extension of operands.

## Test plan
1. WIDTH=32, ADDS 0xFFFFFFFF + 1, AL. Response: result 0, result_we 1, flags next cycle N0 Z1 C1 V0. Then ADC 5+5, AL, no S, on the next cycle: result 0x0B, flags unchanged.
2. SUBS 0x80000000 - 1. Response: result 0x7FFFFFFF, flags N0 Z0 C1 V1. Then RSBS op1=5, op2=3: result 0xFFFFFFFE, N1 C0 V0.
3. CMP 7,7, then ADD with cond NE back-to-back. Response: flags Z1 C1; the second op has executed 0, result_we 0, and flags stay Z1 C1.
4. MOVS op2=0, shift_carry=1, with prior V=1. Response: flags N0 Z1 C1 V1 and result_we 1. TSTS variant: same flags, result_we 0.
5. Hold out_ready=0 for 3 cycles with in_valid=1. Response: in_ready 0 and outputs stable throughout. Release: the consumed result and the next accept occur on the same edge, and the next result appears one cycle later. Also assert flags_wr=1010 together with a CMPS accept: flags become 1010.
6. Assert rst mid-stall with out_valid=1 and flags 1111. Response: immediately out_valid 0 and flags 0000. After release, an ADC 1+1 gives 2 (C=0).
